dmem_arbiter: RTL

Arbitrates the single-ported data memory between two requesters: the CPU memory stage (port C) and the NN weight/output streaming engine (port N). Grants one access per cycle, locks grant to port N for bursts up to a starvation cap, and returns read data registered one cycle after grant. Sits directly in front of the data memory, driving its write-enable, address and write-data inputs and sampling its combinational read port.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_rr_pick.sv | 24 ++
 rtl/dmem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and port identifiers for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB     = 1'b0,
        N_BURST = 1'b1
    } arb_state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_N = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rr_pick
// Purpose  : Two-input round-robin picker; bit 0 = CPU, bit 1 = NN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lastGnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the port that did not win last time gets the slot
        if (req == 2'b11) begin
            gnt = (lastGnt == PORT_N) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : CPU / NN arbiter for the single-ported data memory with NN burst
//            lock, starvation cap and registered read return.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = $clog2(MAX_BURST) + 1
)(
    input  logic                  CLK,
    input  logic                  RST_N,

    input  logic                  cpuReq,
    input  logic                  cpuWe,
    input  logic [ADDR_WIDTH-1:0] cpuAddr,
    input  logic [DATA_WIDTH-1:0] cpuWData,
    output logic                  cpuGnt,
    output logic                  cpuRValid,
    output logic [DATA_WIDTH-1:0] cpuRData,

    input  logic                  nnReq,
    input  logic                  nnWe,
    input  logic [ADDR_WIDTH-1:0] nnAddr,
    input  logic [DATA_WIDTH-1:0] nnWData,
    input  logic                  nnLast,
    output logic                  nnGnt,
    output logic                  nnRValid,
    output logic [DATA_WIDTH-1:0] nnRData,

    output logic                  memWriteEn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam logic [CNT_WIDTH-1:0] c_max_cnt = CNT_WIDTH'(MAX_BURST);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    logic                    r_last_gnt;
    logic                    w_next_last;
    logic [CNT_WIDTH-1:0]    r_burst_cnt;
    logic [CNT_WIDTH-1:0]    w_next_cnt;
    logic [CNT_WIDTH-1:0]    w_cnt_inc;
    logic [1:0]              w_req;
    logic [1:0]              w_pick;
    logic                    w_cpu_gnt;
    logic                    w_nn_gnt;

    logic                    r_cpu_rvalid;
    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic                    r_nn_rvalid;
    logic [DATA_WIDTH-1:0]   r_nn_rdata;

    // Gating requests with reset keeps every grant (and so every write) low in reset
    assign w_req     = {nnReq, cpuReq} & {2{RST_N}};
    assign w_cnt_inc = r_burst_cnt + 1'b1;

    dmem_rr_pick u_pick (
        .req     (w_req),
        .lastGnt (r_last_gnt),
        .gnt     (w_pick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ARB;
            r_last_gnt  <= PORT_N;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_last_gnt  <= w_next_last;
            r_burst_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last_gnt;
        w_next_cnt   = r_burst_cnt;
        w_cpu_gnt    = 1'b0;
        w_nn_gnt     = 1'b0;
        case (r_state)
            ARB: begin
                w_cpu_gnt = w_pick[0];
                w_nn_gnt  = w_pick[1];
                if (w_nn_gnt) begin
                    w_next_last = PORT_N;
                    if (!nnLast) begin
                        w_next_state = N_BURST;
                        w_next_cnt   = CNT_WIDTH'(1);
                    end
                end else if (w_cpu_gnt) begin
                    w_next_last = PORT_C;
                end
            end
            N_BURST: begin
                w_nn_gnt    = w_req[1];
                w_next_last = PORT_N;
                if (w_req[1]) begin
                    w_next_cnt = w_cnt_inc;
                    // Natural end of burst or starvation cap reached
                    if (nnLast || (w_cnt_inc == c_max_cnt)) begin
                        w_next_state = ARB;
                        w_next_cnt   = '0;
                    end
                end else begin
                    w_next_state = ARB;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = ARB;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign cpuGnt = w_cpu_gnt;
    assign nnGnt  = w_nn_gnt;

    always_comb begin
        memWriteEn   = 1'b0;
        memAddr      = '0;
        memWriteData = '0;
        if (w_cpu_gnt) begin
            memWriteEn   = cpuWe;
            memAddr      = cpuAddr;
            memWriteData = cpuWData;
        end else if (w_nn_gnt) begin
            memWriteEn   = nnWe;
            memAddr      = nnAddr;
            memWriteData = nnWData;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_nn_rvalid  <= 1'b0;
            r_nn_rdata   <= '0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpuWe;
            r_nn_rvalid  <= w_nn_gnt & ~nnWe;
            if (w_cpu_gnt && !cpuWe) begin
                r_cpu_rdata <= memReadData;
            end
            if (w_nn_gnt && !nnWe) begin
                r_nn_rdata <= memReadData;
            end
        end
    end

    assign cpuRValid = r_cpu_rvalid;
    assign cpuRData  = r_cpu_rdata;
    assign nnRValid  = r_nn_rvalid;
    assign nnRData   = r_nn_rdata;

endmodule
`default_nettype wire
